// File: rtl/main_mem_model.sv
// Backing-store line memory behind the partitioned cache controller.
// It accepts one line request at a time and answers after a programmable latency.
// It also counts accepted reads and writes, and flags misaligned addresses.

package cache_pkg;

    // Line request from the cache. rw = 1 is a write and rw = 0 is a read.
    typedef struct packed {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic         valid;
    } mem_req_type;

    // Line response. ready pulses for one cycle with the line in data.
    typedef struct packed {
        logic [127:0] data;
        logic         ready;
    } mem_data_type;

endpackage

module main_mem_model
    import cache_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  mem_req_type  mem_req,
    output mem_data_type mem_data,
    output logic         busy,
    output logic [31:0]  rd_count,
    output logic [31:0]  wr_count,
    output logic         misalign
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP,
        ST_DONE
    } state_t;

    // A line's reset contents: each 32-bit word holds its own byte address.
    function automatic logic [127:0] init_line(input int unsigned n);
        logic [127:0] line;
        for (int w = 0; w < 4; w++) begin
            line[w*32 +: 32] = 32'((n << 4) | (w << 2));
        end
        return line;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       wdata_q, wdata_d;
    logic               rw_q, rw_d;
    logic [127:0]       rdata_q, rdata_d;
    logic [31:0]        rd_count_q, rd_count_d;
    logic [31:0]        wr_count_q, wr_count_d;
    logic               misalign_q, misalign_d;
    logic               mem_we;
    logic [127:0]       mem_q [DEPTH];

    // Address bits above the line index alias onto the same line.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_req.addr[31:4+IDX_W];

    // Next-state logic, request capture, counters and completion of the access.
    always_comb begin
        // NOTE: every variable gets a default value first, so no path can leave one
        //       unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        rdata_d    = rdata_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        misalign_d = misalign_q;
        mem_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_req.valid) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    idx_d   = mem_req.addr[4 +: IDX_W];
                    wdata_d = mem_req.data;
                    rw_d    = mem_req.rw;
                    if (mem_req.rw) begin
                        if (wr_count_q != '1) wr_count_d = wr_count_q + 32'd1;
                    end else begin
                        if (rd_count_q != '1) rd_count_d = rd_count_q + 32'd1;
                    end
                    if (mem_req.addr[3:0] != 4'h0) misalign_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    // The write commits and the read samples on the same edge.
                    state_d = ST_RESP;
                    mem_we  = rw_q;
                    rdata_d = rw_q ? wdata_q : mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers. A reset discards any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop
        //       samples values from before the edge.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            rdata_q    <= '0;
            rd_count_q <= '0;
            wr_count_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            rdata_q    <= rdata_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            misalign_q <= misalign_d;
        end
    end

    // Line storage. The reset reloads the address pattern.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this array is reset on purpose. Every simulation starts from the
        //       address pattern, so the array cannot map onto a RAM macro.
        if (!rst_n) begin
            for (int unsigned n = 0; n < DEPTH; n++) begin
                mem_q[n] <= init_line(n);
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign mem_data.data  = rdata_q;
    assign mem_data.ready = (state_q == ST_RESP);
    assign busy           = (state_q != ST_IDLE);
    assign rd_count       = rd_count_q;
    assign wr_count       = wr_count_q;
    assign misalign       = misalign_q;

endmodule
